// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
package cond_pkg;

   // ARM condition field encodings; NV (4'b1111) is the undefined slot.
   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_e;

   // Architectural flag register layout, MSB first: {N,Z,C,V}.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // FlagW bit masks: upper bit updates N,Z; lower bit updates C,V.
   localparam logic [1:0] FLAGW_NZ = 2'b10;
   localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: Cond field against the registered flags.
module cond_eval
   import cond_pkg::*;
#(
   parameter logic UNDEF_EXEC = 1'b0
) (
   input  logic [3:0] cond,
   input  flags_t     flags,
   output logic       condex
);

   // Decode the 4-bit condition field into a single pass/fail result.
   always_comb begin
      condex = UNDEF_EXEC;
      case (cond_e'(cond))
         EQ: condex = flags.z;
         NE: condex = ~flags.z;
         CS: condex = flags.c;
         CC: condex = ~flags.c;
         MI: condex = flags.n;
         PL: condex = ~flags.n;
         VS: condex = flags.v;
         VC: condex = ~flags.v;
         HI: condex = flags.c & ~flags.z;
         LS: condex = ~(flags.c & ~flags.z);
         GE: condex = (flags.n == flags.v);
         LT: condex = (flags.n != flags.v);
         GT: condex = ~flags.z & (flags.n == flags.v);
         LE: condex = ~(~flags.z & (flags.n == flags.v));
         AL: condex = 1'b1;
         default: condex = UNDEF_EXEC;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, condition latch, undefined-
// condition sticky bit and gating of the datapath write enables.
module cond_logic
   import cond_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter logic       UNDEF_EXEC  = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       CondEn,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       UndefClr,
   output logic [3:0] Flags,
   output logic       CondEx,
   output logic       CondExL,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       PCWrite,
   output logic       UndefErr
);

   flags_t flags_q;
   flags_t alu_flags;

   assign alu_flags = flags_t'(ALUFlags);
   assign Flags     = flags_q;

   // Condition is always judged on the registered flags, never on ALUFlags.
   cond_eval #(
      .UNDEF_EXEC (UNDEF_EXEC)
   ) u_cond_eval (
      .cond   (Cond),
      .flags  (flags_q),
      .condex (CondEx)
   );

   // Flag register: each half updates only when requested and the instruction passes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= flags_t'(RESET_FLAGS);
      end else begin
         if (((FlagW & FLAGW_NZ) != 2'b00) && CondEx) begin
            flags_q.n <= alu_flags.n;
            flags_q.z <= alu_flags.z;
         end
         if (((FlagW & FLAGW_CV) != 2'b00) && CondEx) begin
            flags_q.c <= alu_flags.c;
            flags_q.v <= alu_flags.v;
         end
      end
   end

   // Hold the condition result for the later FSM states of this instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         CondExL <= 1'b0;
      end else if (CondEn) begin
         CondExL <= CondEx;
      end
   end

   // Sticky undefined-condition flag; a new set beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         UndefErr <= 1'b0;
      end else if (CondEn && (cond_e'(Cond) == NV)) begin
         UndefErr <= 1'b1;
      end else if (UndefClr) begin
         UndefErr <= 1'b0;
      end
   end

   // Gate write enables; reset_n is folded in so NextPC cannot write during reset.
   always_comb begin
      RegWrite = reset_n & RegW & CondExL;
      MemWrite = reset_n & MemW & CondExL;
      PCWrite  = reset_n & ((PCS & CondExL) | NextPC);
   end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: per-cycle comparison against a
// behavioural model plus hand-computed directed expectations.
module tb_cond_logic;

   logic       clk;
   logic       reset_n;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       CondEn;
   logic       RegW;
   logic       MemW;
   logic       PCS;
   logic       NextPC;
   logic       UndefClr;
   logic [3:0] Flags;
   logic       CondEx;
   logic       CondExL;
   logic       RegWrite;
   logic       MemWrite;
   logic       PCWrite;
   logic       UndefErr;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic        run_cmp  = 1'b0;

   cond_logic #(
      .RESET_FLAGS (4'b0000),
      .UNDEF_EXEC  (1'b0)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .CondEn   (CondEn),
      .RegW     (RegW),
      .MemW     (MemW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .UndefClr (UndefClr),
      .Flags    (Flags),
      .CondEx   (CondEx),
      .CondExL  (CondExL),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .PCWrite  (PCWrite),
      .UndefErr (UndefErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model condition: codes come in pass/fail pairs, the odd code inverts the even one.
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      if (c == 4'd15) return 1'b0;
      case (c >> 1)
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return (c[0] && c != 4'd14) ? !base : base;
   endfunction

   logic [3:0] m_flags = 4'b0000;
   logic       m_latch = 1'b0;
   logic       m_undef = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_flags <= 4'b0000;
         m_latch <= 1'b0;
         m_undef <= 1'b0;
      end else begin
         if (FlagW[1] && model_cond(Cond, m_flags)) m_flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0] && model_cond(Cond, m_flags)) m_flags[1:0] <= ALUFlags[1:0];
         if (CondEn) m_latch <= model_cond(Cond, m_flags);
         if (CondEn && Cond == 4'd15) m_undef <= 1'b1;
         else if (UndefClr) m_undef <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, compare all outputs against the model, away from the clock edge.
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("m_flags",    Flags,           m_flags);
         chk("m_condex",   {3'b0, CondEx},  {3'b0, model_cond(Cond, m_flags)});
         chk("m_condexl",  {3'b0, CondExL}, {3'b0, m_latch});
         chk("m_undef",    {3'b0, UndefErr},{3'b0, m_undef});
         chk("m_regwrite", {3'b0, RegWrite},{3'b0, reset_n && RegW && m_latch});
         chk("m_memwrite", {3'b0, MemWrite},{3'b0, reset_n && MemW && m_latch});
         chk("m_pcwrite",  {3'b0, PCWrite}, {3'b0, reset_n && ((PCS && m_latch) || NextPC)});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      Cond = 4'he; ALUFlags = 4'h0; FlagW = 2'b00; CondEn = 1'b0;
      RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; NextPC = 1'b0; UndefClr = 1'b0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      Cond = 4'he; FlagW = 2'b11; ALUFlags = f;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
   endtask

   initial begin
      idle();
      reset_n = 1'b1;
      RegW = 1'b1; MemW = 1'b1; NextPC = 1'b1;
      #1 reset_n = 1'b0;
      run_cmp = 1'b1;
      step();
      step();
      // Reset: everything cleared and enables forced low, even NextPC.
      chk("rst_flags",    Flags,             4'b0000);
      chk("rst_condexl",  {3'b0, CondExL},   4'b0000);
      chk("rst_undef",    {3'b0, UndefErr},  4'b0000);
      chk("rst_regwrite", {3'b0, RegWrite},  4'b0000);
      chk("rst_memwrite", {3'b0, MemWrite},  4'b0000);
      chk("rst_pcwrite",  {3'b0, PCWrite},   4'b0000);
      reset_n = 1'b1;
      #1;
      chk("rel_pcwrite",  {3'b0, PCWrite},   4'b0001);
      chk("rel_regwrite", {3'b0, RegWrite},  4'b0000);
      step();
      idle();

      // SUBS setting Z and C, then BEQ taken.
      Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b0110;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
      chk("subs_flags", Flags, 4'b0110);
      Cond = 4'h0; CondEn = 1'b1;
      step();
      CondEn = 1'b0;
      chk("beq_condexl", {3'b0, CondExL}, 4'b0001);
      PCS = 1'b1;
      #1;
      chk("beq_pcwrite", {3'b0, PCWrite}, 4'b0001);
      step();
      idle();

      // Partial flag writes.
      load_flags(4'b1111);
      Cond = 4'he; FlagW = 2'b10; ALUFlags = 4'b0000;
      step();
      chk("part_nz", Flags, 4'b0011);
      FlagW = 2'b01;
      step();
      chk("part_cv", Flags, 4'b0000);
      idle();

      // Suppressed instruction: EQ fails on Z=0, no flag write, latch 0.
      Cond = 4'h0; CondEn = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
      step();
      CondEn = 1'b0; FlagW = 2'b00; ALUFlags = 4'h0;
      chk("sup_flags",   Flags,            4'b0000);
      chk("sup_condexl", {3'b0, CondExL},  4'b0000);
      RegW = 1'b1; MemW = 1'b1;
      #1;
      chk("sup_regwrite", {3'b0, RegWrite}, 4'b0000);
      chk("sup_memwrite", {3'b0, MemWrite}, 4'b0000);
      step();
      idle();

      // Sweep all flag values against the compare conditions and NV.
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         for (int c = 8; c < 16; c++) begin
            if (c == 14) continue;
            Cond = 4'(c);
            step();
         end
      end
      idle();

      // Hand-computed condition results pinning the model.
      load_flags(4'b1000);
      Cond = 4'ha; #1 chk("lit_ge_nv", {3'b0, CondEx}, 4'b0000);
      Cond = 4'hb; #1 chk("lit_lt_nv", {3'b0, CondEx}, 4'b0001);
      Cond = 4'hc; #1 chk("lit_gt_nv", {3'b0, CondEx}, 4'b0000);
      Cond = 4'hd; #1 chk("lit_le_nv", {3'b0, CondEx}, 4'b0001);
      load_flags(4'b0010);
      Cond = 4'h8; #1 chk("lit_hi_c",  {3'b0, CondEx}, 4'b0001);
      Cond = 4'h9; #1 chk("lit_ls_c",  {3'b0, CondEx}, 4'b0000);
      Cond = 4'hf; #1 chk("lit_nv",    {3'b0, CondEx}, 4'b0000);
      load_flags(4'b0101);
      Cond = 4'hc; #1 chk("lit_gt_zv", {3'b0, CondEx}, 4'b0000);
      Cond = 4'h0; #1 chk("lit_eq_z",  {3'b0, CondEx}, 4'b0001);
      step();
      idle();

      // Undefined-condition sticky bit.
      Cond = 4'hf; CondEn = 1'b1;
      step();
      idle();
      chk("undef_set", {3'b0, UndefErr}, 4'b0001);
      step();
      chk("undef_hold", {3'b0, UndefErr}, 4'b0001);
      Cond = 4'hf; CondEn = 1'b1; UndefClr = 1'b1;
      step();
      idle();
      chk("undef_setwins", {3'b0, UndefErr}, 4'b0001);
      UndefClr = 1'b1;
      step();
      idle();
      chk("undef_clr", {3'b0, UndefErr}, 4'b0000);
      step();

      // Reset mid-instruction discards the latched condition.
      load_flags(4'b0100);
      Cond = 4'h0; CondEn = 1'b1;
      step();
      idle();
      chk("mid_condexl", {3'b0, CondExL}, 4'b0001);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_condexl", {3'b0, CondExL}, 4'b0000);
      chk("mid_rst_flags",   Flags,           4'b0000);
      step();
      reset_n = 1'b1;
      step();
      step();

      run_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
